// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states and the default reset PC.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: hold on first fetch or pc_wre=0, else jump > taken beq > pc+4.
module next_pc_calc (
    input  logic [31:0] pc_i,
    input  logic [25:0] ir_low_i,
    input  logic        pc_wre_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic        first_i,
    output logic [31:0] next_pc_o
);
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;

    assign pc_plus4   = pc_i + 32'd4;
    assign branch_off = {{14{ir_low_i[15]}}, ir_low_i[15:0], 2'b00};

    always_comb begin
        next_pc_o = pc_plus4;
        if (first_i || !pc_wre_i) begin
            next_pc_o = pc_i;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4[31:28], ir_low_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = pc_plus4 + branch_off;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack bus on each IF strobe.
// Optional ack-wait timeout with sticky fetch_err when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_strobe,
    input  logic                pc_wre,
    input  logic                branch,
    input  logic                jump,
    input  logic                zero,
    instr_fetch_unit_if.master  imem,
    output logic [5:0]          opcode,
    output logic [5:0]          func,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm16,
    output logic [31:0]         pc,
    output logic                instr_valid,
    output logic                busy,
    output logic                strobe_drop
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic                fetch_err
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         first_q, first_d;
    logic         valid_q, valid_d;
    logic         drop_q, drop_d;
    logic [31:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    next_pc_calc u_next_pc (
        .pc_i      (pc_q),
        .ir_low_i  (ir_q[25:0]),
        .pc_wre_i  (pc_wre),
        .branch_i  (branch),
        .jump_i    (jump),
        .zero_i    (zero),
        .first_i   (first_q),
        .next_pc_o (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        first_d = first_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (if_strobe) begin
                    pc_d    = next_pc;
                    first_d = 1'b0;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_FETCH: begin
                // Strobes during a fetch are not queued; they are only reported.
                drop_d = if_strobe;
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            first_q <= 1'b1;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            first_q <= first_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;

    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign imm16       = ir_q[15:0];
    assign func        = ir_q[5:0];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign strobe_drop = drop_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = err_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; a second instance with a high RESET_PC covers jump region bits.
// Timeout scenarios are built only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_strobe = 1'b0, strobe_b = 1'b0;
    logic pc_wre = 1'b0, branch = 1'b0, jump = 1'b0, zero = 1'b0;

    logic [5:0]  opcode, func, b_opcode, b_func;
    logic [4:0]  rs, rt, rd, b_rs, b_rt, b_rd;
    logic [15:0] imm16, b_imm16;
    logic [31:0] pc, b_pc;
    logic        instr_valid, busy, strobe_drop;
    logic        b_valid, b_busy, b_drop;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err, b_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] model_pc    = 32'h0;
    logic [31:0] model_ir    = 32'h0;
    logic        model_first = 1'b1;
    logic [31:0] exp_q[$];

    instr_fetch_unit_if imem ();
    instr_fetch_unit_if imem_b ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .if_strobe(if_strobe), .pc_wre(pc_wre), .branch(branch),
        .jump(jump), .zero(zero), .imem(imem.master), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc(pc), .instr_valid(instr_valid),
        .busy(busy), .strobe_drop(strobe_drop)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err(fetch_err)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'h1000_0010), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .if_strobe(strobe_b), .pc_wre(pc_wre), .branch(branch),
        .jump(jump), .zero(zero), .imem(imem_b.master), .opcode(b_opcode), .func(b_func),
        .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm16(b_imm16), .pc(b_pc), .instr_valid(b_valid),
        .busy(b_busy), .strobe_drop(b_drop)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err(b_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic pw, br, jp, zr);
        logic [31:0] p4;
        p4 = model_pc + 32'd4;
        if (model_first || !pw) return model_pc;
        if (jp) return {p4[31:28], model_ir[25:0], 2'b00};
        if (br && zr) return p4 + {{14{model_ir[15]}}, model_ir[15:0], 2'b00};
        return p4;
    endfunction

    // Strobe, wait for the request, check the address, ack after ack_delay cycles, check IR fields.
    task automatic do_fetch(input logic pw, br, jp, zr, input logic [31:0] word,
                            input int ack_delay, input string tag);
        logic [31:0] exp_addr;
        int waited;
        exp_q.push_back(model_next(pw, br, jp, zr));
        model_pc    = exp_q[$];
        model_first = 1'b0;
        pc_wre = pw; branch = br; jump = jp; zero = zr; if_strobe = 1'b1;
        tick;
        if_strobe = 1'b0;
        {pc_wre, branch, jump, zero} = 4'($urandom);
        waited = 0;
        while (!imem.imem_req && waited < 8) begin
            tick;
            waited++;
        end
        exp_addr = exp_q.pop_front();
        total++;
        if (imem.imem_req !== 1'b1) begin
            bad++; $display("FAIL %s req: got %b want 1", tag, imem.imem_req);
        end
        total++;
        if (imem.imem_addr !== exp_addr || pc !== exp_addr) begin
            bad++; $display("FAIL %s addr: got addr=%h pc=%h want %h", tag, imem.imem_addr, pc, exp_addr);
        end
        repeat (ack_delay) begin
            tick;
            total++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== exp_addr) begin
                bad++; $display("FAIL %s hold: req=%b addr=%h want 1/%h", tag, imem.imem_req, imem.imem_addr, exp_addr);
            end
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = word;
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL %s valid_early: got %b want 0", tag, instr_valid);
        end
        tick;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = $urandom;
        model_ir = word;
        total++;
        if (instr_valid !== 1'b1 || imem.imem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s done: valid=%b req=%b busy=%b want 1/0/0", tag, instr_valid, imem.imem_req, busy);
        end
        total++;
        if ({opcode, rs, rt, imm16} !== model_ir || rd !== model_ir[15:11] || func !== model_ir[5:0]) begin
            bad++; $display("FAIL %s fields: got op=%h rs=%h rt=%h rd=%h imm=%h func=%h want ir=%h",
                            tag, opcode, rs, rt, rd, imm16, func, model_ir);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++;
        if (pc !== 32'h0 || opcode !== 6'h0 || func !== 6'h0) begin
            bad++; $display("FAIL reset_regs: pc=%h op=%h func=%h want 0/0/0", pc, opcode, func);
        end
        total++;
        if (instr_valid !== 1'b0 || imem.imem_req !== 1'b0 || busy !== 1'b0 || strobe_drop !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: valid=%b req=%b busy=%b drop=%b want 0", instr_valid, imem.imem_req, busy, strobe_drop);
        end
        total++;
        if (b_pc !== 32'h1000_0010) begin
            bad++; $display("FAIL reset_pc_b: got %h want 10000010", b_pc);
        end
        rst = 1'b0;
        model_pc = 32'h0; model_ir = 32'h0; model_first = 1'b1;
        tick;
    endtask

    task automatic test_first_fetch;
        do_fetch(1'b1, 1'b0, 1'b0, 1'b0, 32'h3401_0005, 1, "first");
        total++;
        if (opcode !== 6'h0D || imm16 !== 16'h0005 || pc !== 32'h0) begin
            bad++; $display("FAIL first_explicit: op=%h imm=%h pc=%h want 0d/0005/0", opcode, imm16, pc);
        end
    endtask

    task automatic test_jump_region;
        strobe_b = 1'b1;
        tick;
        strobe_b = 1'b0;
        total++;
        if (imem_b.imem_req !== 1'b1 || imem_b.imem_addr !== 32'h1000_0010) begin
            bad++; $display("FAIL jb_first: req=%b addr=%h want 1/10000010", imem_b.imem_req, imem_b.imem_addr);
        end
        imem_b.imem_ack = 1'b1;
        imem_b.imem_rdata = {OP_J, 26'h40};
        tick;
        imem_b.imem_ack = 1'b0;
        total++;
        if (b_valid !== 1'b1 || b_opcode !== OP_J) begin
            bad++; $display("FAIL jb_ir: valid=%b op=%h want 1/02", b_valid, b_opcode);
        end
        pc_wre = 1'b1; jump = 1'b1; branch = 1'b0; zero = 1'b0; strobe_b = 1'b1;
        tick;
        strobe_b = 1'b0; pc_wre = 1'b0; jump = 1'b0;
        total++;
        if (imem_b.imem_addr !== 32'h1000_0100 || b_pc !== 32'h1000_0100) begin
            bad++; $display("FAIL jb_target: addr=%h pc=%h want 10000100", imem_b.imem_addr, b_pc);
        end
        imem_b.imem_ack = 1'b1;
        tick;
        imem_b.imem_ack = 1'b0;
    endtask

    task automatic test_sequential;
        do_fetch(1'b1, 1'b0, 1'b0, 1'b0, {OP_ADDIU, 5'd0, 5'd2, 16'h0007}, 0, "seq");
        total++;
        if (pc !== 32'h4) begin
            bad++; $display("FAIL seq_pc: got %h want 4", pc);
        end
        do_fetch(1'b0, 1'b1, 1'b1, 1'b1, {OP_ORI, 5'd1, 5'd3, 16'h00FF}, 0, "refetch");
        total++;
        if (pc !== 32'h4) begin
            bad++; $display("FAIL refetch_pc: got %h want 4", pc);
        end
    endtask

    task automatic test_branch;
        do_fetch(1'b1, 1'b0, 1'b0, 1'b0, {OP_BEQ, 5'd0, 5'd0, 16'hFFFE}, 0, "to8a");
        do_fetch(1'b1, 1'b1, 1'b0, 1'b1, {OP_ORI, 5'd0, 5'd1, 16'h0001}, 0, "beq_taken");
        total++;
        if (pc !== 32'h4) begin
            bad++; $display("FAIL beq_taken_pc: got %h want 4", pc);
        end
        do_fetch(1'b1, 1'b0, 1'b0, 1'b0, {OP_BEQ, 5'd0, 5'd0, 16'hFFFE}, 1, "to8b");
        do_fetch(1'b1, 1'b1, 1'b0, 1'b0, {OP_BEQ, 5'd0, 5'd0, 16'h0003}, 0, "beq_not");
        total++;
        if (pc !== 32'hC) begin
            bad++; $display("FAIL beq_not_pc: got %h want c", pc);
        end
        do_fetch(1'b1, 1'b1, 1'b0, 1'b1, {OP_J, 26'h40}, 2, "beq_fwd");
        total++;
        if (pc !== 32'h1C) begin
            bad++; $display("FAIL beq_fwd_pc: got %h want 1c", pc);
        end
        do_fetch(1'b1, 1'b1, 1'b1, 1'b1, {OP_LW, 5'd1, 5'd2, 16'h0010}, 0, "jump_prio");
        total++;
        if (pc !== 32'h100) begin
            bad++; $display("FAIL jump_prio_pc: got %h want 100", pc);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            do_fetch(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                     int'($urandom_range(0, 2)), "b2b");
        end
    endtask

    task automatic test_drop_and_reset;
        logic [31:0] held;
        model_pc = model_next(1'b1, 1'b0, 1'b0, 1'b0);
        pc_wre = 1'b1; branch = 1'b0; jump = 1'b0; if_strobe = 1'b1;
        tick;
        held = imem.imem_addr;
        total++;
        if (held !== model_pc) begin
            bad++; $display("FAIL drop_addr0: got %h want %h", held, model_pc);
        end
        pc_wre = 1'b1; jump = 1'b1; if_strobe = 1'b1;
        tick;
        if_strobe = 1'b0; jump = 1'b0;
        total++;
        if (strobe_drop !== 1'b1 || imem.imem_req !== 1'b1 || imem.imem_addr !== held || pc !== held) begin
            bad++; $display("FAIL drop_pulse: drop=%b req=%b addr=%h pc=%h want 1/1/%h", strobe_drop, imem.imem_req, imem.imem_addr, pc, held);
        end
        tick;
        total++;
        if (strobe_drop !== 1'b0 || imem.imem_addr !== held) begin
            bad++; $display("FAIL drop_end: drop=%b addr=%h want 0/%h", strobe_drop, imem.imem_addr, held);
        end
        rst = 1'b1;
        #1;
        total++;
        if (imem.imem_req !== 1'b0 || pc !== 32'h0 || busy !== 1'b0 || instr_valid !== 1'b0 || opcode !== 6'h0) begin
            bad++; $display("FAIL async_rst: req=%b pc=%h busy=%b valid=%b op=%h want 0", imem.imem_req, pc, busy, instr_valid, opcode);
        end
        tick;
        rst = 1'b0;
        model_pc = 32'h0; model_ir = 32'h0; model_first = 1'b1;
        tick;
    endtask

    task automatic test_ack_idle;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'hFFFF_FFFF;
        tick;
        imem.imem_ack = 1'b0;
        total++;
        if (opcode !== 6'h0 || func !== 6'h0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ack_idle: op=%h func=%h valid=%b busy=%b want 0", opcode, func, instr_valid, busy);
        end
        do_fetch(1'b1, 1'b0, 1'b1, 1'b0, {OP_SW, 5'd4, 5'd5, 16'h0008}, 0, "after_rst");
        total++;
        if (pc !== 32'h0) begin
            bad++; $display("FAIL after_rst_pc: got %h want 0", pc);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        logic [5:0] op_before;
        do_fetch(1'b1, 1'b0, 1'b0, 1'b0, {OP_ORI, 5'd2, 5'd2, 16'h1234}, 3, "ack_wins");
        total++;
        if (fetch_err !== 1'b0) begin
            bad++; $display("FAIL ack_wins_err: got %b want 0", fetch_err);
        end
        op_before = opcode;
        pc_wre = 1'b1; branch = 1'b0; jump = 1'b0; if_strobe = 1'b1;
        tick;
        if_strobe = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick;
        end
        total++;
        if (imem.imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            bad++; $display("FAIL to_wait: req=%b err=%b want 1/0", imem.imem_req, fetch_err);
        end
        tick;
        total++;
        if (fetch_err !== 1'b1 || imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || opcode !== op_before) begin
            bad++; $display("FAIL to_expire: err=%b req=%b valid=%b op=%h want 1/0/0/%h", fetch_err, imem.imem_req, instr_valid, opcode, op_before);
        end
        model_pc = pc;
        do_fetch(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 0, "to_recover");
        total++;
        if (fetch_err !== 1'b1) begin
            bad++; $display("FAIL to_sticky: got %b want 1", fetch_err);
        end
    endtask
`endif

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'h0;
        imem_b.imem_ack = 1'b0;
        imem_b.imem_rdata = 32'h0;
        test_reset;
        test_first_fetch;
        test_jump_region;
        test_sequential;
        test_branch;
        test_back_to_back;
        test_drop_and_reset;
        test_ack_idle;
`ifdef FETCH_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
